fu_mult_pipe: RTL and testbench

//  Pipelined integer multiply functional unit: receiving end of the issue->FU interface.

---
 rtl/fu_mult_pipe_if.sv | 42 ++++
 rtl/fu_mult_pipe.sv | 117 +++++++++++
 tb/tb_fu_mult_pipe.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fu_mult_pipe_if.sv
// Issue->FU and FU->complete bundle for the pipelined multiplier.
// slave: the FU side (takes issue, drives done); master: issue + complete side.
interface fu_mult_pipe_if #(
    parameter int XLEN  = 32,
    parameter int PR_W  = 6,
    parameter int AR_W  = 5,
    parameter int ROB_W = 5
);
    logic             issue_valid;
    logic             issue_ready;
    logic [XLEN-1:0]  rs1_value;
    logic [XLEN-1:0]  rs2_value;
    logic [4:0]       mult_func;
    logic [PR_W-1:0]  pr_idx;
    logic [AR_W-1:0]  ar_idx;
    logic [ROB_W-1:0] rob_idx;

    logic             done_valid;
    logic             done_ready;
    logic [XLEN-1:0]  done_value;
    logic [PR_W-1:0]  done_pr_idx;
    logic [AR_W-1:0]  done_ar_idx;
    logic [ROB_W-1:0] done_rob_idx;

    modport slave (
        input  issue_valid, rs1_value, rs2_value, mult_func,
        input  pr_idx, ar_idx, rob_idx,
        output issue_ready,
        output done_valid, done_value,
        output done_pr_idx, done_ar_idx, done_rob_idx,
        input  done_ready
    );

    modport master (
        output issue_valid, rs1_value, rs2_value, mult_func,
        output pr_idx, ar_idx, rob_idx,
        input  issue_ready,
        input  done_valid, done_value,
        input  done_pr_idx, done_ar_idx, done_rob_idx,
        output done_ready
    );
endinterface

// File: rtl/fu_mult_pipe.sv
// Pipelined MUL/MULH/MULHSU/MULHU unit: STAGES-deep shift-add over 2*XLEN bits.
// Ports: clock, reset (sync, high), squash, bus (fu_mult_pipe_if.slave).
module fu_mult_pipe #(
    parameter int STAGES = 4,
    parameter int XLEN   = 32,
    parameter int PR_W   = 6,
    parameter int AR_W   = 5,
    parameter int ROB_W  = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          squash,
    fu_mult_pipe_if.slave bus
);
    localparam int PW = 2 * XLEN;
    localparam int C  = PW / STAGES;

    localparam logic [4:0] ALU_MUL    = 5'h0a;
    localparam logic [4:0] ALU_MULH   = 5'h0b;
    localparam logic [4:0] ALU_MULHSU = 5'h0c;
    localparam logic [4:0] ALU_MULHU  = 5'h0d;

    typedef struct packed {
        logic             valid;
        logic [4:0]       func;
        logic [PR_W-1:0]  pr;
        logic [AR_W-1:0]  ar;
        logic [ROB_W-1:0] rob;
        logic [PW-1:0]    mcand;
        logic [PW-1:0]    mplier;
        logic [PW-1:0]    sum;
    } stage_t;

    stage_t          s_q  [STAGES];
    stage_t          s_d  [STAGES];
    stage_t          in_s [STAGES];
    logic            advance;
    logic            a_sgn;
    logic            b_sgn;
    logic [XLEN-1:0] res;

    // The whole pipe moves in lock-step; a held result freezes every stage.
    assign advance         = !s_q[STAGES-1].valid || bus.done_ready;
    assign bus.issue_ready = advance;

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (bus.mult_func)
            ALU_MUL, ALU_MULH: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            ALU_MULHSU: a_sgn = 1'b1;
            default: ;
        endcase
    end

    // Stage k folds in chunk k of the multiplier; the running sum
    // is mod 2^PW, so signed operands only need sign extension.
    always_comb begin
        in_s[0]        = '0;
        in_s[0].valid  = bus.issue_valid;
        in_s[0].func   = bus.mult_func;
        in_s[0].pr     = bus.pr_idx;
        in_s[0].ar     = bus.ar_idx;
        in_s[0].rob    = bus.rob_idx;
        in_s[0].mcand  = {{XLEN{a_sgn & bus.rs1_value[XLEN-1]}},
                          bus.rs1_value};
        in_s[0].mplier = {{XLEN{b_sgn & bus.rs2_value[XLEN-1]}},
                          bus.rs2_value};
        for (int k = 1; k < STAGES; k++) begin
            in_s[k] = s_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            s_d[k]     = in_s[k];
            s_d[k].sum = in_s[k].sum
                       + ((in_s[k].mcand << (k * C))
                          * PW'(in_s[k].mplier[k*C +: C]));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= '0;
            end
        end else if (squash) begin
            for (int k = 0; k < STAGES; k++) begin
                s_q[k].valid <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= s_d[k];
            end
        end
    end

    // Unknown encodings still retire, carrying a zero result.
    always_comb begin
        res = '0;
        case (s_q[STAGES-1].func)
            ALU_MUL:
                res = s_q[STAGES-1].sum[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:
                res = s_q[STAGES-1].sum[PW-1:XLEN];
            default:
                res = '0;
        endcase
    end

    assign bus.done_valid   = s_q[STAGES-1].valid;
    assign bus.done_value   = res;
    assign bus.done_pr_idx  = s_q[STAGES-1].pr;
    assign bus.done_ar_idx  = s_q[STAGES-1].ar;
    assign bus.done_rob_idx = s_q[STAGES-1].rob;
endmodule

// File: tb/tb_fu_mult_pipe.sv
// Self-checking bench for fu_mult_pipe: directed table, corner sequences,
// and randomized traffic against a queue/age reference model.
module tb_fu_mult_pipe;
    localparam int STAGES = 4;
    localparam logic [4:0] F_MUL    = 5'h0a;
    localparam logic [4:0] F_MULH   = 5'h0b;
    localparam logic [4:0] F_MULHSU = 5'h0c;
    localparam logic [4:0] F_MULHU  = 5'h0d;

    logic clk = 1'b0;
    logic reset;
    logic squash;
    always #5 clk = ~clk;

    fu_mult_pipe_if bus ();

    fu_mult_pipe #(.STAGES(STAGES)) dut (
        .clock  (clk),
        .reset  (reset),
        .squash (squash),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] val;
        logic [5:0]  pr;
        logic [4:0]  ar;
        logic [4:0]  rob;
        int          age;
    } exp_t;

    typedef struct {
        logic [4:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    exp_t        q[$];
    logic [4:0]  rob_log[$];
    int          checks   = 0;
    int          failures = 0;
    bit          last_acc;
    bit          last_ready;
    int          n_done   = 0;

    function automatic logic [31:0] ref_mul(
        input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (f)
            F_MUL:    begin p = sa * sb; return p[31:0];  end
            F_MULH:   begin p = sa * sb; return p[63:32]; end
            F_MULHSU: begin p = sa * ub; return p[63:32]; end
            F_MULHU:  begin p = ua * ub; return p[63:32]; end
            default:  return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [4:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] pr, input logic [4:0] ar,
                         input logic [4:0] rob);
        bus.issue_valid = v;
        bus.mult_func   = f;
        bus.rs1_value   = a;
        bus.rs2_value   = b;
        bus.pr_idx      = pr;
        bus.ar_idx      = ar;
        bus.rob_idx     = rob;
    endtask

    task automatic idle();
        drive(1'b0, 5'h0, 32'h0, 32'h0, 6'h0, 5'h0, 5'h0);
    endtask

    // Called at posedge+1 with inputs set; checks, updates model,
    // and returns at the next posedge+1.
    task automatic tick();
        bit   dv_m, adv;
        exp_t e;
        #1;
        dv_m = (q.size() > 0) && (q[0].age == STAGES);
        last_ready = bus.issue_ready;
        chk("done_valid", {63'h0, bus.done_valid}, {63'h0, dv_m});
        chk("issue_ready", {63'h0, bus.issue_ready},
            {63'h0, (!dv_m || bus.done_ready)});
        if (dv_m && bus.done_valid) begin
            chk("done_value", {32'h0, bus.done_value}, {32'h0, q[0].val});
            chk("done_pr", {58'h0, bus.done_pr_idx}, {58'h0, q[0].pr});
            chk("done_ar", {59'h0, bus.done_ar_idx}, {59'h0, q[0].ar});
            chk("done_rob", {59'h0, bus.done_rob_idx}, {59'h0, q[0].rob});
        end
        adv = !dv_m || bus.done_ready;
        last_acc = 1'b0;
        if (reset || squash) begin
            q.delete();
        end else if (adv) begin
            if (dv_m) begin
                e = q.pop_front();
                rob_log.push_back(e.rob);
                n_done++;
            end
            foreach (q[i]) q[i].age++;
            if (bus.issue_valid) begin
                e.val = ref_mul(bus.mult_func, bus.rs1_value, bus.rs2_value);
                e.pr  = bus.pr_idx;
                e.ar  = bus.ar_idx;
                e.rob = bus.rob_idx;
                e.age = 1;
                q.push_back(e);
                last_acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vt[8];
        int   n_iss, base, cyc;
        bit   saw_stall, have;
        logic [4:0]  rf;
        logic [31:0] ra, rb;
        logic [5:0]  rpr;
        logic [4:0]  rar, rrob;

        vt[0] = '{F_MUL,    32'd7,        32'd8,        32'd56};
        vt[1] = '{F_MULH,   32'h80000000, 32'h80000000, 32'h40000000};
        vt[2] = '{F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vt[3] = '{F_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
        vt[4] = '{F_MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1};
        vt[5] = '{5'h00,    32'd1234,     32'd5678,     32'h0};
        vt[6] = '{F_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1};
        vt[7] = '{F_MULH,   32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF};

        reset  = 1'b1;
        squash = 1'b0;
        bus.done_ready = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done_valid", {63'h0, bus.done_valid}, 64'h0);
        chk("rst_issue_ready", {63'h0, bus.issue_ready}, 64'h1);
        chk("rst_done_value", {32'h0, bus.done_value}, 64'h0);
        chk("rst_done_pr", {58'h0, bus.done_pr_idx}, 64'h0);
        reset = 1'b0;

        // Latency: MUL 7*8 visible exactly STAGES edges after acceptance.
        drive(1'b1, F_MUL, 32'd7, 32'd8, 6'd3, 5'd3, 5'd2);
        tick();
        idle();
        tick();
        tick();
        chk("lat_early", {63'h0, bus.done_valid}, 64'h0);
        tick();
        chk("lat_valid", {63'h0, bus.done_valid}, 64'h1);
        chk("lat_value", {32'h0, bus.done_value}, 64'd56);
        chk("lat_pr", {58'h0, bus.done_pr_idx}, 64'd3);
        chk("lat_rob", {59'h0, bus.done_rob_idx}, 64'd2);
        tick();

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vt[i].f, vt[i].a, vt[i].b,
                  6'(i + 10), 5'(i), 5'(i + 1));
            tick();
            idle();
            repeat (STAGES - 1) tick();
            chk($sformatf("vec%0d_valid", i),
                {63'h0, bus.done_valid}, 64'h1);
            chk($sformatf("vec%0d_value", i),
                {32'h0, bus.done_value}, {32'h0, vt[i].exp});
            chk($sformatf("vec%0d_pr", i),
                {58'h0, bus.done_pr_idx}, 64'(i + 10));
            tick();
        end

        // Back-pressure: six back-to-back ops, sink stalls cycles 5..9.
        n_iss     = 0;
        base      = n_done;
        saw_stall = 1'b0;
        rob_log.delete();
        for (int c = 0; c < 40; c++) begin
            bus.done_ready = !(c >= 5 && c <= 9);
            if (n_iss < 6)
                drive(1'b1, F_MUL, 32'(n_iss + 1), 32'(n_iss + 100),
                      6'(n_iss + 40), 5'(n_iss), 5'(n_iss + 16));
            else
                idle();
            tick();
            if (bus.issue_valid && !last_ready) saw_stall = 1'b1;
            if (last_acc) n_iss++;
        end
        bus.done_ready = 1'b1;
        chk("bp_stalled", {63'h0, saw_stall}, 64'h1);
        chk("bp_count", 64'(n_done - base), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < rob_log.size())
                chk($sformatf("bp_order%0d", i),
                    {59'h0, rob_log[i]}, 64'(i + 16));
        end

        // Squash with three ops in flight and one offered.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, F_MULHU, 32'(i + 5), 32'h12345678,
                  6'(i), 5'(i), 5'(i + 20));
            tick();
        end
        squash = 1'b1;
        drive(1'b1, F_MUL, 32'd9, 32'd9, 6'd50, 5'd7, 5'd25);
        tick();
        squash = 1'b0;
        idle();
        for (int i = 0; i < STAGES; i++) begin
            chk("sq_quiet", {63'h0, bus.done_valid}, 64'h0);
            tick();
        end
        drive(1'b1, F_MULHU, 32'hDEADBEEF, 32'h10, 6'd33, 5'd9, 5'd30);
        tick();
        idle();
        repeat (STAGES - 1) tick();
        chk("sq_after_valid", {63'h0, bus.done_valid}, 64'h1);
        chk("sq_after_value", {32'h0, bus.done_value}, 64'h0000000D);
        chk("sq_after_rob", {59'h0, bus.done_rob_idx}, 64'd30);
        tick();

        // Reset while a result is being held by the sink.
        bus.done_ready = 1'b0;
        drive(1'b1, F_MUL, 32'd3, 32'd3, 6'd9, 5'd4, 5'd7);
        tick();
        idle();
        repeat (STAGES) tick();
        chk("hold_valid", {63'h0, bus.done_valid}, 64'h1);
        chk("hold_value", {32'h0, bus.done_value}, 64'd9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.done_ready = 1'b1;
        chk("rstmid_valid", {63'h0, bus.done_valid}, 64'h0);
        chk("rstmid_value", {32'h0, bus.done_value}, 64'h0);
        chk("rstmid_pr", {58'h0, bus.done_pr_idx}, 64'h0);
        chk("rstmid_rob", {59'h0, bus.done_rob_idx}, 64'h0);

        // Randomized traffic with back-pressure and rare squashes.
        n_iss = 0;
        cyc   = 0;
        have  = 1'b0;
        rf = '0; ra = '0; rb = '0; rpr = '0; rar = '0; rrob = '0;
        while (n_iss < 1000 && cyc < 20000) begin
            if (!have && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 9))
                    0:       rf = 5'($urandom_range(0, 31));
                    1, 2:    rf = F_MUL;
                    3, 4:    rf = F_MULH;
                    5, 6:    rf = F_MULHSU;
                    default: rf = F_MULHU;
                endcase
                case ($urandom_range(0, 4))
                    0:       ra = 32'hFFFFFFFF;
                    1:       ra = 32'h80000000;
                    default: ra = $urandom;
                endcase
                rb   = ($urandom_range(0, 4) == 0) ? 32'h7FFFFFFF : $urandom;
                rpr  = 6'($urandom);
                rar  = 5'($urandom);
                rrob = 5'($urandom);
                have = 1'b1;
            end
            drive(have, rf, ra, rb, rpr, rar, rrob);
            bus.done_ready = ($urandom_range(0, 9) < 7);
            squash = ($urandom_range(0, 99) == 0);
            tick();
            if (have && (last_acc || squash)) begin
                have = 1'b0;
                n_iss++;
            end
            cyc++;
        end
        squash = 1'b0;
        idle();
        bus.done_ready = 1'b1;
        repeat (STAGES + 2) tick();
        chk("rand_budget", {63'h0, (n_iss >= 1000)}, 64'h1);
        chk("rand_drained", 64'(q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
